// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU operation codes, EX-stage FSM states
// and small helpers used by the execute stage.
package mips_pkg;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;
    localparam logic [3:0] AluMul = 4'b1000;

    // Shift-add multiplier runs one iteration per bit of the multiplier.
    localparam logic [4:0] MulLastIter = 5'd31;

    typedef enum logic {
        StIdle,
        StBusy
    } exState_e;

    function automatic logic [31:0] calcBranchTarget(input logic [31:0] pc,
                                                     input logic [31:0] imm);
        return pc + (imm << 2);
    endfunction

endpackage

// File: rtl/stage_ex_if.sv
// ID/EX inputs, EX/MEM latch outputs and the stall back-pressure of the execute stage.
interface stage_ex_if;

    logic [31:0] pc_ex;
    logic [3:0]  aluOp;
    logic        isJump;
    logic        isNotConditional;
    logic        isEq;
    logic        memWrite;
    logic        memRead;
    logic [1:0]  wbi;
    logic        aluSrc;
    logic        regDst;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] extendedInstr;
    logic [4:0]  regAddr1;
    logic [4:0]  regAddr2;

    logic [31:0] aluResult;
    logic [31:0] storeData;
    logic [4:0]  writeAddr;
    logic        memWrite_mem;
    logic        memRead_mem;
    logic [1:0]  wbi_mem;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        stall;

    // Upstream (ID) side: drives the instruction, observes results and stall.
    modport master (
        output pc_ex, aluOp, isJump, isNotConditional, isEq, memWrite, memRead, wbi,
               aluSrc, regDst, reg1, reg2, extendedInstr, regAddr1, regAddr2,
        input  aluResult, storeData, writeAddr, memWrite_mem, memRead_mem, wbi_mem,
               branchTaken, branchTarget, stall
    );

    // Execute stage side.
    modport slave (
        input  pc_ex, aluOp, isJump, isNotConditional, isEq, memWrite, memRead, wbi,
               aluSrc, regDst, reg1, reg2, extendedInstr, regAddr1, regAddr2,
        output aluResult, storeData, writeAddr, memWrite_mem, memRead_mem, wbi_mem,
               branchTaken, branchTarget, stall
    );

endinterface

// File: rtl/ex_alu.sv
// Single-cycle combinational ALU; multiply is handled by the iterative unit in stage_ex,
// so MUL and any undefined code produce zero here.
module ex_alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  aluOp,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (aluOp)
            AluAnd:  result = a & b;
            AluOr:   result = a | b;
            AluAdd:  result = a + b;
            AluSub:  result = a - b;
            AluSlt:  result = {31'b0, $signed(a) < $signed(b)};
            AluNor:  result = ~(a | b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/stage_ex.sv
// MIPS execute stage: single-cycle ALU and branch resolution, plus a 32-iteration
// shift-add multiplier that stalls upstream and feeds the registered EX/MEM latch.
module stage_ex
    import mips_pkg::*;
(
    input logic       clock,
    input logic       reset,
    stage_ex_if.slave ex
);

    logic [31:0] opB;
    logic [31:0] aluOut;
    logic [31:0] accNext;
    logic [31:0] targetNext;
    logic [4:0]  writeAddrNext;
    logic        isMul;
    logic        branchCond;

    exState_e    state;
    logic [4:0]  cnt;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] capStore;
    logic [4:0]  capAddr;
    logic        capMemWrite;
    logic        capMemRead;
    logic [1:0]  capWbi;

    assign opB           = ex.aluSrc ? ex.extendedInstr : ex.reg2;
    assign isMul         = (ex.aluOp == AluMul);
    assign writeAddrNext = ex.regDst ? ex.regAddr2 : ex.regAddr1;
    assign targetNext    = calcBranchTarget(ex.pc_ex, ex.extendedInstr);
    assign branchCond    = ex.isJump & (ex.isNotConditional | (ex.isEq == (ex.reg1 == ex.reg2)));
    assign accNext       = acc + (mplier[0] ? mcand : 32'd0);

    ex_alu uAlu (
        .a      (ex.reg1),
        .b      (opB),
        .aluOp  (ex.aluOp),
        .result (aluOut)
    );

    // Hold upstream from MUL acceptance until the last iteration cycle.
    assign ex.stall = (state == StIdle) ? isMul : (cnt != MulLastIter);

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= StIdle;
            cnt             <= '0;
            acc             <= '0;
            mcand           <= '0;
            mplier          <= '0;
            capStore        <= '0;
            capAddr         <= '0;
            capMemWrite     <= 1'b0;
            capMemRead      <= 1'b0;
            capWbi          <= '0;
            ex.aluResult    <= '0;
            ex.storeData    <= '0;
            ex.writeAddr    <= '0;
            ex.memWrite_mem <= 1'b0;
            ex.memRead_mem  <= 1'b0;
            ex.wbi_mem      <= '0;
            ex.branchTaken  <= 1'b0;
            ex.branchTarget <= '0;
        end else begin
            // Bubble by default; overridden below whenever a real result retires.
            ex.aluResult    <= '0;
            ex.storeData    <= '0;
            ex.writeAddr    <= '0;
            ex.memWrite_mem <= 1'b0;
            ex.memRead_mem  <= 1'b0;
            ex.wbi_mem      <= '0;
            ex.branchTaken  <= 1'b0;
            ex.branchTarget <= '0;

            case (state)
                StIdle: begin
                    if (isMul) begin
                        mcand       <= ex.reg1;
                        mplier      <= opB;
                        acc         <= '0;
                        cnt         <= '0;
                        capStore    <= ex.reg2;
                        capAddr     <= writeAddrNext;
                        capMemWrite <= ex.memWrite;
                        capMemRead  <= ex.memRead;
                        capWbi      <= ex.wbi;
                        state       <= StBusy;
                    end else begin
                        ex.aluResult    <= aluOut;
                        ex.storeData    <= ex.reg2;
                        ex.writeAddr    <= writeAddrNext;
                        ex.memWrite_mem <= ex.memWrite;
                        ex.memRead_mem  <= ex.memRead;
                        ex.wbi_mem      <= ex.wbi;
                        ex.branchTaken  <= branchCond;
                        ex.branchTarget <= targetNext;
                    end
                end
                StBusy: begin
                    acc    <= accNext;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == MulLastIter) begin
                        ex.aluResult    <= accNext;
                        ex.storeData    <= capStore;
                        ex.writeAddr    <= capAddr;
                        ex.memWrite_mem <= capMemWrite;
                        ex.memRead_mem  <= capMemRead;
                        ex.wbi_mem      <= capWbi;
                        state           <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_ex.sv
// Self-checking bench for stage_ex: scoreboard of expected EX/MEM results per instruction.
module tb_stage_ex;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    stage_ex_if exIf ();

    stage_ex dut (
        .clock (clock),
        .reset (reset),
        .ex    (exIf)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  aluOp;
        logic        isJump;
        logic        isNC;
        logic        isEq;
        logic        memWrite;
        logic        memRead;
        logic [1:0]  wbi;
        logic        aluSrc;
        logic        regDst;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] imm;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
    } instr_t;

    typedef struct packed {
        logic [31:0] aluResult;
        logic [31:0] storeData;
        logic [4:0]  writeAddr;
        logic        memWrite;
        logic        memRead;
        logic [1:0]  wbi;
        logic        branchTaken;
        logic [31:0] branchTarget;
    } exOut_t;

    typedef struct {
        instr_t      i;
        logic [31:0] res;
        logic        taken;
        logic [31:0] tgt;
    } tcase_t;

    exOut_t expQ[$];
    int nChecks = 0;
    int nFails = 0;

    task automatic driveInstr(input instr_t i);
        exIf.pc_ex            = i.pc;
        exIf.aluOp            = i.aluOp;
        exIf.isJump           = i.isJump;
        exIf.isNotConditional = i.isNC;
        exIf.isEq             = i.isEq;
        exIf.memWrite         = i.memWrite;
        exIf.memRead          = i.memRead;
        exIf.wbi              = i.wbi;
        exIf.aluSrc           = i.aluSrc;
        exIf.regDst           = i.regDst;
        exIf.reg1             = i.reg1;
        exIf.reg2             = i.reg2;
        exIf.extendedInstr    = i.imm;
        exIf.regAddr1         = i.ra1;
        exIf.regAddr2         = i.ra2;
    endtask

    function automatic exOut_t sampleOut();
        exOut_t o;
        o.aluResult    = exIf.aluResult;
        o.storeData    = exIf.storeData;
        o.writeAddr    = exIf.writeAddr;
        o.memWrite     = exIf.memWrite_mem;
        o.memRead      = exIf.memRead_mem;
        o.wbi          = exIf.wbi_mem;
        o.branchTaken  = exIf.branchTaken;
        o.branchTarget = exIf.branchTarget;
        return o;
    endfunction

    function automatic instr_t mkInstr(input logic [3:0] op, input logic [31:0] r1,
                                       input logic [31:0] r2, input logic [31:0] imm,
                                       input logic src, input int k);
        instr_t i;
        i          = '0;
        i.pc       = 32'h400;
        i.aluOp    = op;
        i.reg1     = r1;
        i.reg2     = r2;
        i.imm      = imm;
        i.aluSrc   = src;
        i.wbi      = k[1:0];
        i.memWrite = k[0];
        i.memRead  = k[1];
        i.regDst   = k[2];
        i.ra1      = 5'(k + 1);
        i.ra2      = 5'(k + 17);
        return i;
    endfunction

    // Pass-through fields only; result, branch outcome and target come from constants.
    function automatic exOut_t expFor(input instr_t i, input logic [31:0] res,
                                      input logic taken, input logic [31:0] tgt);
        exOut_t o;
        o.aluResult    = res;
        o.storeData    = i.reg2;
        o.writeAddr    = i.regDst ? i.ra2 : i.ra1;
        o.memWrite     = i.memWrite;
        o.memRead      = i.memRead;
        o.wbi          = i.wbi;
        o.branchTaken  = taken;
        o.branchTarget = tgt;
        return o;
    endfunction

    // Clocks through a MUL; reports stall length and any non-bubble output seen while stalled.
    task automatic mulWait(input bit scramble, output int stallCycles, output int badBubbles,
                           output bit finished);
        bit stop;
        stallCycles = 0;
        badBubbles  = 0;
        finished    = 1'b0;
        stop        = 1'b0;
        for (int k = 0; k < 40 && !stop; k++) begin
            #1;
            if (exIf.stall !== 1'b1) begin
                finished = (exIf.stall === 1'b0);
                stop     = 1'b1;
            end else begin
                stallCycles++;
            end
            @(posedge clock);
            @(negedge clock);
            if (!stop) begin
                if (sampleOut() !== '0) badBubbles++;
                if (scramble) begin
                    exIf.reg1     = $urandom;
                    exIf.reg2     = $urandom;
                    exIf.wbi      = 2'($urandom_range(0, 3));
                    exIf.regAddr2 = 5'($urandom_range(0, 31));
                    exIf.memWrite = ~exIf.memWrite;
                end
            end
        end
    endtask

    task automatic test_reset();
        exOut_t got;
        reset = 1'b1;
        driveInstr('0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        got = sampleOut();
        nChecks++;
        if (got !== '0) begin
            nFails++;
            $display("FAIL reset_outputs: got %h, want 0", got);
        end
        nChecks++;
        if (exIf.stall !== 1'b0) begin
            nFails++;
            $display("FAIL reset_stall: got %b, want 0", exIf.stall);
        end
    endtask

    task automatic runTable(input string name, input tcase_t tab[$]);
        exOut_t got;
        exOut_t exp;
        foreach (tab[k]) begin
            driveInstr(tab[k].i);
            expQ.push_back(expFor(tab[k].i, tab[k].res, tab[k].taken, tab[k].tgt));
            #1;
            nChecks++;
            if (exIf.stall !== 1'b0) begin
                nFails++;
                $display("FAIL %s_stall[%0d]: got %b, want 0", name, k, exIf.stall);
            end
            @(posedge clock);
            @(negedge clock);
            got = sampleOut();
            exp = expQ.pop_front();
            nChecks++;
            if (got !== exp) begin
                nFails++;
                $display("FAIL %s[%0d]: got res=%h sd=%h wa=%0d mw=%b mr=%b wbi=%0d bt=%b tgt=%h, want res=%h sd=%h wa=%0d mw=%b mr=%b wbi=%0d bt=%b tgt=%h",
                         name, k, got.aluResult, got.storeData, got.writeAddr, got.memWrite,
                         got.memRead, got.wbi, got.branchTaken, got.branchTarget,
                         exp.aluResult, exp.storeData, exp.writeAddr, exp.memWrite,
                         exp.memRead, exp.wbi, exp.branchTaken, exp.branchTarget);
            end
        end
    endtask

    task automatic test_alu();
        tcase_t tab[$];
        tcase_t c;
        c.taken = 1'b0;
        c.i = mkInstr(4'b0010, 32'd5, 32'h1234, 32'hFFFF_FFFF, 1'b1, 0);
        c.res = 32'd4;          c.tgt = 32'h3FC;  tab.push_back(c);
        c.i = mkInstr(4'b0111, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0, 1);
        c.res = 32'd1;          c.tgt = 32'h400;  tab.push_back(c);
        c.i = mkInstr(4'b0111, 32'd1, 32'hFFFF_FFFE, 32'd0, 1'b0, 2);
        c.res = 32'd0;          c.tgt = 32'h400;  tab.push_back(c);
        c.i = mkInstr(4'b0110, 32'd0, 32'd1, 32'd0, 1'b0, 3);
        c.res = 32'hFFFF_FFFF;  c.tgt = 32'h400;  tab.push_back(c);
        c.i = mkInstr(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h10, 1'b0, 4);
        c.res = 32'h00F0_1200;  c.tgt = 32'h440;  tab.push_back(c);
        c.i = mkInstr(4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0, 5);
        c.res = 32'hFFF0_FF34;  c.tgt = 32'h400;  tab.push_back(c);
        c.i = mkInstr(4'b1100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0, 6);
        c.res = 32'h000F_00CB;  c.tgt = 32'h400;  tab.push_back(c);
        c.i = mkInstr(4'b0011, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1'b0, 7);
        c.res = 32'd0;          c.tgt = 32'h400;  tab.push_back(c);
        c.i = mkInstr(4'b0010, 32'hFFFF_FFFF, 32'h55, 32'd2, 1'b1, 12);
        c.res = 32'd1;          c.tgt = 32'h408;  tab.push_back(c);
        runTable("alu", tab);
    endtask

    task automatic test_branch();
        tcase_t tab[$];
        tcase_t c;
        c.tgt = 32'hF8;
        // BEQ equal / not equal, BNE equal / not equal, unconditional, no jump.
        c.i = mkInstr(4'b0110, 32'd7, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
        c.i.pc = 32'h100; c.i.isJump = 1'b1; c.i.isEq = 1'b1;
        c.res = 32'd0;         c.taken = 1'b1; tab.push_back(c);
        c.i.reg2 = 32'd8;
        c.res = 32'hFFFF_FFFF; c.taken = 1'b0; tab.push_back(c);
        c.i.isEq = 1'b0;
        c.res = 32'hFFFF_FFFF; c.taken = 1'b1; tab.push_back(c);
        c.i.reg2 = 32'd7;
        c.res = 32'd0;         c.taken = 1'b0; tab.push_back(c);
        c.i.reg2 = 32'd8; c.i.isNC = 1'b1;
        c.res = 32'hFFFF_FFFF; c.taken = 1'b1; tab.push_back(c);
        c.i.reg2 = 32'd7; c.i.isJump = 1'b0; c.i.isEq = 1'b1;
        c.res = 32'd0;         c.taken = 1'b0; tab.push_back(c);
        runTable("branch", tab);
    endtask

    task automatic test_mul();
        instr_t i;
        exOut_t exp;
        exOut_t got;
        int sc;
        int bad;
        bit fin;
        i = mkInstr(4'b1000, 32'h0001_0001, 32'h0001_0001, 32'h5, 1'b0, 6);
        i.wbi = 2'd3; i.memRead = 1'b1; i.memWrite = 1'b0;
        i.isJump = 1'b1; i.isNC = 1'b1;
        exp = expFor(i, 32'h0002_0001, 1'b0, 32'd0);
        driveInstr(i);
        expQ.push_back(exp);
        mulWait(1'b1, sc, bad, fin);
        nChecks++;
        if (!fin || sc != 32) begin
            nFails++;
            $display("FAIL mul_stall_cycles: got %0d (finished=%b), want 32", sc, fin);
        end
        nChecks++;
        if (bad != 0) begin
            nFails++;
            $display("FAIL mul_bubbles: got %0d non-bubble cycles, want 0", bad);
        end
        got = sampleOut();
        got.branchTarget = '0;
        exp = expQ.pop_front();
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL mul_result: got res=%h wa=%0d wbi=%0d mr=%b mw=%b bt=%b, want res=%h wa=%0d wbi=%0d mr=%b mw=%b bt=%b",
                     got.aluResult, got.writeAddr, got.wbi, got.memRead, got.memWrite,
                     got.branchTaken, exp.aluResult, exp.writeAddr, exp.wbi, exp.memRead,
                     exp.memWrite, exp.branchTaken);
        end
        driveInstr('0);
    endtask

    task automatic test_reset_abort();
        instr_t i;
        exOut_t exp;
        exOut_t got;
        int sc;
        int bad;
        bit fin;
        int leaks;
        i = mkInstr(4'b1000, 32'h1234, 32'd5, 32'd0, 1'b0, 3);
        driveInstr(i);
        repeat (11) @(posedge clock);
        @(negedge clock);
        nChecks++;
        if (exIf.stall !== 1'b1) begin
            nFails++;
            $display("FAIL abort_busy_stall: got %b, want 1", exIf.stall);
        end
        reset = 1'b1;
        driveInstr('0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        nChecks++;
        if (exIf.stall !== 1'b0 || sampleOut() !== '0) begin
            nFails++;
            $display("FAIL abort_after_reset: got stall=%b out=%h, want stall=0 out=0",
                     exIf.stall, sampleOut());
        end
        leaks = 0;
        for (int k = 0; k < 34; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (exIf.stall !== 1'b0 || sampleOut() !== '0) leaks++;
        end
        nChecks++;
        if (leaks != 0) begin
            nFails++;
            $display("FAIL abort_no_result: got %0d non-idle cycles, want 0", leaks);
        end
        i = mkInstr(4'b1000, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b0, 2);
        driveInstr(i);
        expQ.push_back(expFor(i, 32'hFFFF_FFFD, 1'b0, 32'd0));
        mulWait(1'b0, sc, bad, fin);
        got = sampleOut();
        got.branchTarget = '0;
        exp = expQ.pop_front();
        nChecks++;
        if (!fin || sc != 32 || bad != 0 || got !== exp) begin
            nFails++;
            $display("FAIL abort_next_mul: got res=%h stall=%0d bad=%0d, want res=%h stall=32 bad=0",
                     got.aluResult, sc, bad, exp.aluResult);
        end
        driveInstr('0);
    endtask

    task automatic test_back_to_back();
        instr_t i;
        exOut_t exp;
        exOut_t got;
        int sc;
        int bad;
        bit fin;
        logic [31:0] a [2];
        logic [31:0] b [2];
        logic [31:0] p [2];
        a[0] = 32'd6; b[0] = 32'd7; p[0] = 32'd42;
        a[1] = 32'd2; b[1] = 32'd2; p[1] = 32'd4;
        for (int n = 0; n < 2; n++) begin
            i = mkInstr(4'b1000, a[n], b[n], 32'd0, 1'b0, 5 + n);
            driveInstr(i);
            expQ.push_back(expFor(i, p[n], 1'b0, 32'd0));
            mulWait(1'b0, sc, bad, fin);
            nChecks++;
            if (!fin || sc != 32 || bad != 0) begin
                nFails++;
                $display("FAIL b2b_stall[%0d]: got %0d cycles bad=%0d, want 32 bad=0", n, sc, bad);
            end
            got = sampleOut();
            got.branchTarget = '0;
            exp = expQ.pop_front();
            nChecks++;
            if (got !== exp) begin
                nFails++;
                $display("FAIL b2b_result[%0d]: got res=%h wa=%0d wbi=%0d, want res=%h wa=%0d wbi=%0d",
                         n, got.aluResult, got.writeAddr, got.wbi, exp.aluResult,
                         exp.writeAddr, exp.wbi);
            end
        end
        driveInstr('0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mul();
        test_reset_abort();
        test_back_to_back();
        @(posedge clock);
        @(negedge clock);
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("FAIL scoreboard_drained: got %0d pending, want 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/stage_ex.md
STAGE_EX -- requirements
Module: stage_ex

Interface
REQ-001 SHALL: reset, synchronous, active-high; clock clock.
REQ-002 SHALL ports (name  direction  width  meaning): clock  in  1  rising-edge clock; reset  in  1  sync active-high reset.
REQ-003 SHALL ports: pc_ex in 32, PC of the instruction; aluOp in 4, ALU operation; isJump in 1, branch/jump; isNotConditional in 1, unconditional jump; isEq in 1, branch-on-equal (0 = on-not-equal).
REQ-004 SHALL ports: memWrite in 1; memRead in 1; wbi in 2, write-back select; aluSrc in 1, 1 = use immediate as operand B; regDst in 1, 1 = destination is regAddr2.
REQ-005 SHALL ports: reg1 in 32, rs value; reg2 in 32, rt value; extendedInstr in 32, sign-extended immediate; regAddr1 in 5, rt field; regAddr2 in 5, rd field.
REQ-006 SHALL ports: aluResult out 32; storeData out 32; writeAddr out 5; memWrite_mem out 1; memRead_mem out 1; wbi_mem out 2; branchTaken out 1; branchTarget out 32 (all registered, EX/MEM latch).
REQ-007 SHALL port: stall out 1, combinational, 1 = upstream stage holds its ID/EX outputs unchanged.

Function
REQ-008 SHALL: operand A = reg1; operand B = aluSrc ? extendedInstr : reg2.
REQ-009 SHALL aluOp codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR, 1000 MUL; any other code gives result 0.
REQ-010 SHALL: ADD/SUB wrap modulo 2^32, no overflow flag; MUL result = low 32 bits of A*B.
REQ-011 SHALL: writeAddr = regDst ? regAddr2 : regAddr1; storeData = reg2.
REQ-012 SHALL: branch condition = isJump & (isNotConditional | (isEq == (reg1 == reg2))); branchTarget = pc_ex + (extendedInstr << 2), modulo 2^32.
REQ-013 SHALL: non-MUL ops have latency 1 clock: all outputs updated at the edge at which inputs are present; stall = 0.
REQ-014 SHALL FSM states: IDLE, BUSY; 5-bit iteration counter cnt.
REQ-015 SHALL: in IDLE with aluOp = MUL, stall = 1; next edge captures A, B, writeAddr, storeData, memWrite, memRead, wbi; clears accumulator; cnt = 0; goes to BUSY.
REQ-016 SHALL: in BUSY, each edge does one shift-add step (acc += mcand if mplier[0]; mcand <<= 1; mplier >>= 1); cnt increments.
REQ-017 SHALL: in BUSY, stall = (cnt != 31); at the edge with cnt = 31, the final step is applied, the product and captured controls load into the EX/MEM outputs, and the FSM returns to IDLE.
REQ-018 SHALL: stall is high for exactly 32 cycles per MUL; the result is visible 33 edges after the MUL is first presented.
REQ-019 SHALL: every edge at which stall = 1 loads a bubble: memWrite_mem = 0, memRead_mem = 0, wbi_mem = 0, branchTaken = 0, other outputs 0.
REQ-020 SHALL: inputs that change during BUSY (protocol violation) do not affect the product in flight.
REQ-021 SHALL: MUL with isJump = 1 ignores the branch; branchTaken = 0 on the MUL result.
REQ-022 SHALL: back-to-back MULs are handled: after the return to IDLE, a new MUL presented on the following cycle is accepted per REQ-015.

Reset
REQ-023 SHALL: reset forces IDLE, cnt = 0, acc = 0, stall = 0 (unless the IDLE MUL term applies in the next cycle), and all registered outputs = 0.
REQ-024 SHALL: reset asserted mid-MUL aborts it with no result produced.

Structure
REQ-025 SHALL: aluOp code constants and FSM state encodings live in the shared package mips_pkg.
REQ-026 SHALL: the combinational ALU (REQ-009 except MUL) is the sub-module ex_alu; the MUL FSM and EX/MEM latch stay in stage_ex.

Verification
REQ-027 SHALL cover: ADD, aluSrc = 1, reg1 = 5, extendedInstr = 0xFFFFFFFF -> aluResult 4 after 1 edge; stall stays 0.
REQ-028 SHALL cover: SLT reg1 = 0xFFFFFFFE, reg2 = 1, aluSrc = 0 -> aluResult 1; SUB 0 - 1 -> 0xFFFFFFFF.
REQ-029 SHALL cover: BEQ (isJump = 1, isEq = 1) reg1 = reg2 = 7, pc_ex = 0x100, imm = 0xFFFFFFFE -> branchTaken 1, branchTarget 0xF8; reg2 = 8 -> branchTaken 0.
REQ-030 SHALL cover: MUL 0x10001 * 0x10001 -> stall high for 32 cycles, then aluResult 0x00020001 with wbi_mem as captured, and bubbles output during the stall.
REQ-031 SHALL cover: reset at BUSY cycle 10 -> next cycle IDLE, outputs 0, stall 0; a subsequent MUL 3 * 0xFFFFFFFF -> 0xFFFFFFFD.
REQ-032 SHALL cover: two consecutive MULs (6 * 7, then 2 * 2) -> 42, then 4 after another 32 stall cycles.
